// File: rtl/regfile16_if.sv
// Operand-fetch bus for regfile16: one write port, one paired read
// launch, and the registered X/Y operands with their VALID strobe.
interface regfile16_if #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
);
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic             WE;
   logic [AW-1:0]    WADDR;
   logic [WIDTH-1:0] WDATA;
   logic             RE;
   logic [AW-1:0]    RADDR_X;
   logic [AW-1:0]    RADDR_Y;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             VALID;

   modport master (
      output WE, WADDR, WDATA, RE, RADDR_X, RADDR_Y,
      input  X, Y, VALID
   );

   modport slave (
      input  WE, WADDR, WDATA, RE, RADDR_X, RADDR_Y,
      output X, Y, VALID
   );
endinterface

// File: rtl/regfile16.sv
// Register file with hardwired-zero R0, one write port and two registered
// read ports that feed the bitwise logic units; same-edge writes bypass.
module regfile16 #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
) (
   input  logic       clk,
   input  logic       rst,
   regfile16_if.slave bus
);
   localparam int             AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [AW:0]    NREGS_W = (AW + 1)'(NREGS);

   logic [WIDTH-1:0] regs_r [NREGS];
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] y_r;
   logic             valid_r;
   logic [WIDTH-1:0] x_next_s;
   logic [WIDTH-1:0] y_next_s;

   // R0 and addresses past the last register are not backed by storage.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < NREGS_W);
   endfunction

   // Operand selection: zero for dead addresses, write data on a same-edge hit.
   always_comb begin
      x_next_s = '0;
      y_next_s = '0;
      if (!addr_live(bus.RADDR_X)) begin
         x_next_s = '0;
      end else if (bus.WE && (bus.WADDR == bus.RADDR_X)) begin
         x_next_s = bus.WDATA;
      end else begin
         x_next_s = regs_r[bus.RADDR_X];
      end
      if (!addr_live(bus.RADDR_Y)) begin
         y_next_s = '0;
      end else if (bus.WE && (bus.WADDR == bus.RADDR_Y)) begin
         y_next_s = bus.WDATA;
      end else begin
         y_next_s = regs_r[bus.RADDR_Y];
      end
   end

   // Storage update and registered operand launch; reset overrides both.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
         x_r     <= '0;
         y_r     <= '0;
         valid_r <= 1'b0;
      end else begin
         regs_r[0] <= '0;
         for (int i = 1; i < NREGS; i++) begin
            if (bus.WE && (bus.WADDR == AW'(i))) begin
               regs_r[i] <= bus.WDATA;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
         valid_r <= bus.RE;
         if (bus.RE) begin
            x_r <= x_next_s;
            y_r <= y_next_s;
         end else begin
            x_r <= x_r;
            y_r <= y_r;
         end
      end
   end

   assign bus.X     = x_r;
   assign bus.Y     = y_r;
   assign bus.VALID = valid_r;
endmodule
